// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C transaction arbiter.
// States, bus widths and the index-width helper used by the arbiter and its picker.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_ARB,
        ARB_ISSUE,
        ARB_WAIT_DONE,
        ARB_COMPLETE
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2c_txn_arbiter_if.sv
// Requester-side and master-side signal bundle of the I2C transaction arbiter.
// The arbiter uses the slave modport; the environment driving it uses the master modport.
interface i2c_txn_arbiter_if
    import i2c_pkg::*;
#(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]            i_req;
    logic [N_REQ-1:0]            i_req_rw;
    logic [I2C_ADDR_W*N_REQ-1:0] i_req_addr;
    logic [I2C_DATA_W*N_REQ-1:0] i_req_wdata;
    logic [N_REQ-1:0]            o_gnt;
    logic [N_REQ-1:0]            o_done;
    logic [I2C_DATA_W-1:0]       o_rdata;
    logic                        o_nack;
    logic                        o_timeout;
    logic                        o_start;
    logic                        o_rw;
    logic [I2C_ADDR_W-1:0]       o_address;
    logic [I2C_DATA_W-1:0]       o_w_byte;
    logic                        i_busy;
    logic                        i_done;
    logic                        i_nack;
    logic [I2C_DATA_W-1:0]       i_r_byte;

    modport slave (
        input  i_req, i_req_rw, i_req_addr, i_req_wdata,
        input  i_busy, i_done, i_nack, i_r_byte,
        output o_gnt, o_done, o_rdata, o_nack, o_timeout,
        output o_start, o_rw, o_address, o_w_byte
    );

    modport master (
        output i_req, i_req_rw, i_req_addr, i_req_wdata,
        output i_busy, i_done, i_nack, i_r_byte,
        input  o_gnt, o_done, o_rdata, o_nack, o_timeout,
        input  o_start, o_rw, o_address, o_w_byte
    );

endinterface

// File: rtl/i2c_rr_grant.sv
// Combinational round-robin picker: first asserted request at or after i_ptr, wrapping.
// Produces the winner as one-hot and as an index, plus an any-request flag.
module i2c_rr_grant #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [IDX_W-1:0] w_k;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path can infer a latch.
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        w_k      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_k = IDX_W'((int'(i_ptr) + i) % N_REQ);
            if (!o_any && i_req[w_k]) begin
                o_any         = 1'b1;
                o_idx         = w_k;
                o_onehot[w_k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one single-byte I2C master between N_REQ requesters.
// Optional watchdog abort enabled with `define I2C_ARB_TIMEOUT_EN.
module i2c_txn_arbiter
    import i2c_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    i2c_txn_arbiter_if.slave  io_bus
);

    localparam int IDX_W = idx_w(N_REQ);

    arb_state_t             r_state;
    arb_state_t             w_next_state;
    logic [IDX_W-1:0]       r_ptr;
    logic [N_REQ-1:0]       r_gnt;
    logic                   r_rw;
    logic [I2C_ADDR_W-1:0]  r_addr;
    logic [I2C_DATA_W-1:0]  r_wbyte;
    logic [I2C_DATA_W-1:0]  r_rdata;
    logic                   r_nack;
    logic                   r_timeout;

    logic [N_REQ-1:0]       w_win_onehot;
    logic [IDX_W-1:0]       w_win_idx;
    logic [IDX_W-1:0]       w_ptr_next;
    logic                   w_win_any;
    logic                   w_in_xfer;
    logic                   w_done_seen;
    logic                   w_tmo_hit;
    logic [I2C_ADDR_W-1:0]  w_addr_arr  [N_REQ];
    logic [I2C_DATA_W-1:0]  w_wdata_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_addr_arr[g]  = io_bus.i_req_addr[g*I2C_ADDR_W +: I2C_ADDR_W];
        assign w_wdata_arr[g] = io_bus.i_req_wdata[g*I2C_DATA_W +: I2C_DATA_W];
    end

    i2c_rr_grant #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_grant (
        .i_req    (io_bus.i_req),
        .i_ptr    (r_ptr),
        .o_onehot (w_win_onehot),
        .o_idx    (w_win_idx),
        .o_any    (w_win_any)
    );

    assign w_ptr_next  = (w_win_idx == IDX_W'(N_REQ - 1)) ? '0 : w_win_idx + IDX_W'(1);
    assign w_in_xfer   = (r_state == ARB_ISSUE) || (r_state == ARB_WAIT_DONE);
    assign w_done_seen = w_in_xfer && io_bus.i_done;

`ifdef I2C_ARB_TIMEOUT_EN
    // Counter reads k-1 in the k-th cycle after ARB, so matching TIMEOUT_CYC-2 lands o_done on cycle TIMEOUT_CYC.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 2);
    logic [15:0] r_tmo_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_tmo_cnt <= '0;
        else if (r_state == ARB_ARB)
            r_tmo_cnt <= '0;
        else if (w_in_xfer)
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end

    assign w_tmo_hit = w_in_xfer && (r_tmo_cnt == TMO_LAST);
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYC == 0);
    assign w_tmo_hit    = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_state <= ARB_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE:      if (|io_bus.i_req) w_next_state = ARB_ARB;
            ARB_ARB:       w_next_state = w_win_any ? ARB_ISSUE : ARB_IDLE;
            ARB_ISSUE: begin
                if (io_bus.i_done || w_tmo_hit) w_next_state = ARB_COMPLETE;
                else if (io_bus.i_busy)         w_next_state = ARB_WAIT_DONE;
            end
            ARB_WAIT_DONE: if (io_bus.i_done || w_tmo_hit) w_next_state = ARB_COMPLETE;
            ARB_COMPLETE:  w_next_state = ARB_IDLE;
            default:       w_next_state = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!i_rst_n) begin
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_rw      <= 1'b0;
            r_addr    <= '0;
            r_wbyte   <= '0;
            r_rdata   <= '0;
            r_nack    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == ARB_ARB && w_win_any) begin
                r_gnt   <= w_win_onehot;
                r_rw    <= io_bus.i_req_rw[w_win_idx];
                r_addr  <= w_addr_arr[w_win_idx];
                r_wbyte <= w_wdata_arr[w_win_idx];
                r_ptr   <= w_ptr_next;
            end
            // A normal completion wins over a watchdog hit in the same cycle.
            if (w_done_seen) begin
                if (r_rw) r_rdata <= io_bus.i_r_byte;
                r_nack    <= io_bus.i_nack;
                r_timeout <= 1'b0;
            end else if (w_tmo_hit) begin
                r_rdata   <= '0;
                r_nack    <= 1'b1;
                r_timeout <= 1'b1;
            end
            if (r_state == ARB_COMPLETE) r_gnt <= '0;
        end
    end

    assign io_bus.o_gnt     = r_gnt;
    assign io_bus.o_done    = (r_state == ARB_COMPLETE) ? r_gnt : '0;
    assign io_bus.o_start   = (r_state == ARB_ISSUE);
    assign io_bus.o_rw      = r_rw;
    assign io_bus.o_address = r_addr;
    assign io_bus.o_w_byte  = r_wbyte;
    assign io_bus.o_rdata   = r_rdata;
    assign io_bus.o_nack    = r_nack;
    assign io_bus.o_timeout = r_timeout;

endmodule
